// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through, no-write-allocate data cache with line refill FSM
// Optional DCACHE_STATS_EN adds stat_hits/stat_misses lookup counters.
module dcache_dm #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int INDEX_BITS    = 3,
  parameter int WORD_BITS     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req_valid,
  input  logic                     cpu_req_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_req_ready,
  output logic                     cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     mem_req_valid,
  output logic                     mem_req_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_req_ready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_rdata_valid
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  localparam int SETS   = 2**INDEX_BITS;
  localparam int WB     = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int OFF_LO = WORD_BITS + 2;
  localparam int TAG_W  = ADDRESS_WIDTH - INDEX_BITS - OFF_LO;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RWAIT, RESP, WTHRU} state_t;
  state_t state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     req_we;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [WB-1:0]            cnt;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [SETS-1:0]          valid_q;
  logic [TAG_W-1:0]         tag_mem  [SETS];
  logic [DATA_WIDTH-1:0]    line_mem [SETS][2**WB];

  logic [TAG_W-1:0]         req_tag;
  logic [INDEX_BITS-1:0]    req_index;
  logic [WB-1:0]            req_word;
  logic [DATA_WIDTH-1:0]    line_word;
  logic [ADDRESS_WIDTH-1:0] refill_addr;
  logic                     hit, last_word, resp_load, fill_beat;

  assign req_tag   = req_addr[ADDRESS_WIDTH-1:OFF_LO+INDEX_BITS];
  assign req_index = req_addr[OFF_LO+INDEX_BITS-1:OFF_LO];

  generate
    if (WORD_BITS > 0) begin : g_word
      assign req_word = req_addr[WORD_BITS+1:2];
    end else begin : g_noword
      assign req_word = '0;
    end
  endgenerate

  assign hit         = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign line_word   = line_mem[req_index][req_word];
  assign last_word   = (cnt == WB'(2**WORD_BITS - 1));
  assign fill_beat   = (state == RWAIT) && mem_rdata_valid;
  assign refill_addr = {req_addr[ADDRESS_WIDTH-1:OFF_LO], {OFF_LO{1'b0}}} | (ADDRESS_WIDTH'(cnt) << 2);

  // Load data is driven straight from the line on a response and held otherwise.
  assign cpu_rdata = resp_load ? line_word : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    resp_load      = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (req_we) begin
          state_nxt = WTHRU;
        end else if (hit) begin
          cpu_resp_valid = 1'b1;
          resp_load      = 1'b1;
          state_nxt      = IDLE;
        end else begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_req_valid = 1'b1;
        mem_addr      = refill_addr;
        if (mem_req_ready) state_nxt = RWAIT;
      end
      RWAIT: begin
        if (mem_rdata_valid) state_nxt = last_word ? RESP : REFILL;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        resp_load      = 1'b1;
        state_nxt      = IDLE;
      end
      WTHRU: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_addr      = req_addr;
        mem_wdata     = req_wdata;
        if (mem_req_ready) begin
          cpu_resp_valid = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      valid_q   <= '0;
    end else begin
      if (state == IDLE && cpu_req_valid) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_req_we;
        req_wdata <= cpu_wdata;
      end
      if (resp_load) rdata_q <= line_word;
      // The victim line is invalidated up front so a half-written line never hits.
      if (state == LOOKUP && !req_we && !hit) begin
        valid_q[req_index] <= 1'b0;
        cnt                <= '0;
      end
      if (fill_beat) begin
        if (last_word) valid_q[req_index] <= 1'b1;
        else           cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && req_we && hit) line_mem[req_index][req_word] <= req_wdata;
    if (fill_beat) begin
      line_mem[req_index][cnt] <= mem_rdata;
      if (last_word) tag_mem[req_index] <= req_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit) stat_hits   <= stat_hits + 32'd1;
      else     stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - scoreboard bench for dcache_dm with a handshaking memory model
module tb_dcache_dm;
  logic        clk, rst;
  logic        cpu_req_valid, cpu_req_we, cpu_req_ready, cpu_resp_valid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req_valid, mem_req_we, mem_req_ready, mem_rdata_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  dcache_dm dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata), .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    int          rd_base;
    int          wr_base;
    int          exp_rd;
    int          exp_wr;
    int          acc_cyc;
    int          exp_lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] bk[logic [31:0]];
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] rd_addr, stall_addr;
  logic        rd_pend, hold_data;
  logic        m_valid[8];
  logic [25:0] m_tag[8];
  int          reads_cnt, writes_cnt, stall_left, cyc;
  int          n_checks, n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] bk_rd(input logic [31:0] a);
    if (bk.exists(a)) return bk[a];
    return 32'hD000_0000 ^ a;
  endfunction

  // Memory model: decides at the falling edge, read data follows one cycle after accept.
  initial begin
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata_valid = 1'b0;
      if (rd_pend && !hold_data) begin
        mem_rdata_valid = 1'b1;
        mem_rdata = bk_rd(rd_addr);
        rd_pend = 1'b0;
      end
      if (mem_req_valid && !rst) begin
        if (!mem_rdata_valid) begin
          mem_rdata_valid = 1'b1;
          mem_rdata = 32'hDEAD_BEEF;
        end
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
          check("stall_addr", mem_addr, stall_addr);
          check("stall_cpu_ready", cpu_req_ready, 0);
        end else begin
          mem_req_ready = 1'b1;
          if (mem_req_we) begin
            bk[mem_addr] = mem_wdata;
            wr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
            writes_cnt++;
          end else begin
            rd_addr = mem_addr;
            rd_pend = 1'b1;
            rd_log.push_back(mem_addr);
            reads_cnt++;
          end
        end
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (cpu_resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.is_load) check("rdata", cpu_rdata, e.data);
          check("mem_reads", reads_cnt - e.rd_base, e.exp_rd);
          check("mem_writes", writes_cnt - e.wr_base, e.exp_wr);
          if (e.exp_lat >= 0) check("hit_latency", cyc - e.acc_cyc, e.exp_lat);
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data);
    exp_t        e;
    int          n;
    logic [2:0]  idx;
    logic [25:0] tg;
    logic        hit;
    idx = addr[5:3];
    tg  = addr[31:6];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    n = 0;
    while (!cpu_req_ready && n < 100) begin @(negedge clk); n++; end
    if (!cpu_req_ready) check("req_ready_timeout", 0, 1);
    e.is_load = !we;
    e.data    = exp_data;
    e.rd_base = reads_cnt;
    e.wr_base = writes_cnt;
    e.exp_rd  = (!we && !hit) ? 2 : 0;
    e.exp_wr  = we ? 1 : 0;
    e.acc_cyc = cyc;
    e.exp_lat = (!we && hit) ? 1 : -1;
    sb.push_back(e);
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    if (!we && !hit) begin m_valid[idx] = 1'b1; m_tag[idx] = tg; end
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      check("resp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          n, base;
    logic [31:0] a, d;
    logic [31:0] pool[7];
    pool = '{32'h40, 32'h44, 32'h48, 32'h80, 32'h84, 32'h100, 32'h140};
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    rd_pend = 1'b0; hold_data = 1'b0; stall_left = 0; stall_addr = '0; rd_addr = '0;
    reads_cnt = 0; writes_cnt = 0; cyc = 0; n_checks = 0; n_errors = 0;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
    bk[32'h40] = 32'hAAAA_0000;
    bk[32'h44] = 32'hAAAA_0001;
    repeat (3) @(negedge clk);
    check("rst_cpu_req_ready", cpu_req_ready, 1);
    check("rst_cpu_resp_valid", cpu_resp_valid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_we", mem_req_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    rd_log.delete();
    do_req(1'b0, 32'h40, 0, 32'hAAAA_0000);
    check("fill_nbeats", rd_log.size(), 2);
    check("fill_addr0", rd_log[0], 32'h40);
    check("fill_addr1", rd_log[1], 32'h44);
    do_req(1'b0, 32'h44, 0, 32'hAAAA_0001);

    do_req(1'b0, 32'h80, 0, bk_rd(32'h80));
    do_req(1'b0, 32'h40, 0, 32'hAAAA_0000);

    wr_log.delete(); wr_data_log.delete();
    do_req(1'b1, 32'h44, 32'h1234_5678, 0);
    check("wthru_addr", wr_log[0], 32'h44);
    check("wthru_data", wr_data_log[0], 32'h1234_5678);
    do_req(1'b0, 32'h44, 0, 32'h1234_5678);

    do_req(1'b1, 32'h100, 32'hCAFE_F00D, 0);
    do_req(1'b0, 32'h100, 0, 32'hCAFE_F00D);

    stall_addr = 32'h200;
    stall_left = 5;
    do_req(1'b0, 32'h200, 0, bk_rd(32'h200));
    check("stall_consumed", stall_left, 0);

    hold_data = 1'b1;
    base = reads_cnt;
    cpu_req_valid = 1'b1; cpu_addr = 32'h300;
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_addr = '0;
    n = 0;
    while (reads_cnt == base && n < 50) begin @(negedge clk); n++; end
    check("rwait_reached", reads_cnt - base, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_cpu_req_ready", cpu_req_ready, 1);
    check("abort_mem_req_valid", mem_req_valid, 0);
    check("abort_cpu_resp_valid", cpu_resp_valid, 0);
    check("abort_cpu_rdata", cpu_rdata, 0);
    check("abort_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0; rd_pend = 1'b0; hold_data = 1'b0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    @(negedge clk);
    do_req(1'b0, 32'h300, 0, bk_rd(32'h300));
    do_req(1'b0, 32'h40, 0, 32'hAAAA_0000);

    for (int k = 0; k < 24; k++) begin
      a = pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        do_req(1'b1, a, d, 0);
      end else begin
        do_req(1'b0, a, 0, bk_rd(a));
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised direct-mapped data cache between the pipeline memory stage and data memory.
- Successor to the single-cycle combinational cache:
  - configurable sets and line size;
  - valid/tag array held in flops with asynchronous clear;
  - multi-word line refill FSM with a valid/ready memory handshake;
  - write-through with no-write-allocate.
- One outstanding CPU request at a time.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; the byte offset is log2(DATA_WIDTH/8) = 2 bits.
- INDEX_BITS, 3, number of sets = 2**INDEX_BITS.
- WORD_BITS, 1, words per line = 2**WORD_BITS; 0 gives one-word lines.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDRESS_WIDTH  word-aligned byte address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_req_ready  out  1  cache can accept a request.
- cpu_resp_valid  out  1  one-cycle pulse: load data valid, or store complete.
- cpu_rdata  out  DATA_WIDTH  load data, valid with cpu_resp_valid.
- mem_req_valid  out  1  memory request.
- mem_req_we  out  1  memory write.
- mem_addr  out  ADDRESS_WIDTH  word address of the memory access.
- mem_wdata  out  DATA_WIDTH  write-through data.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_rdata  in  DATA_WIDTH  read data.
- mem_rdata_valid  in  1  read data beat valid.

Behaviour:
- Address split:
  - tag = cpu_addr[ADDRESS_WIDTH-1 : INDEX_BITS+WORD_BITS+2]
  - index = [INDEX_BITS+WORD_BITS+1 : WORD_BITS+2]
  - word = [WORD_BITS+1 : 2]
- Storage per set: valid bit, tag, line data. Only the valid bits are reset; data and tag storage are not reset.
- Reset: all valid bits = 0, state = IDLE, refill word counter = 0. All outputs = 0 except cpu_req_ready = 1.
- cpu_req_ready = 1 only in IDLE. A request is accepted on cpu_req_valid & cpu_req_ready, and the address, we and wdata are registered.
- States:
  - IDLE: on accept -> LOOKUP.
  - LOOKUP: hit = valid[index] & (stored tag == tag).
    - Load hit: cpu_rdata = line word; pulse cpu_resp_valid this cycle; -> IDLE. Total latency is 1 cycle after accept.
    - Load miss: -> REFILL with counter = 0.
    - Store, hit or miss: on hit, write the word into the line. -> WTHRU.
  - REFILL:
    - mem_req_valid = 1, mem_req_we = 0, mem_addr = {tag, index, counter, 2'b00}.
    - Hold the request stable until mem_req_ready, then -> RWAIT.
  - RWAIT:
    - On mem_rdata_valid, write mem_rdata into line word[counter].
    - If counter is not the last word: counter + 1, -> REFILL.
    - If it is the last word: set valid[index] = 1, write the tag, -> RESP.
    - The valid bit stays 0 during refill.
  - RESP: cpu_rdata = requested word of the new line; cpu_resp_valid = 1; -> IDLE.
  - WTHRU:
    - mem_req_valid = 1, mem_req_we = 1, mem_addr = registered address, mem_wdata = registered wdata.
    - On mem_req_ready: pulse cpu_resp_valid, -> IDLE.
    - A store miss does not allocate and leaves the valid bits unchanged.
- mem_rdata_valid is ignored outside RWAIT.
- mem_req_ready is ignored when mem_req_valid = 0.
- Reset asserted mid-refill or mid-write:
  - immediate abort; mem_req_valid drops asynchronously;
  - the partially filled line stays invalid;
  - no CPU response is produced.
- Back-to-back requests: a new request is accepted in the cycle after the response, when IDLE is re-entered.
- cpu_rdata is held at its last value when cpu_resp_valid = 0. It is 0 after reset.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - adds outputs stat_hits and stat_misses, 32 bits each;
  - each counts accepted requests at LOOKUP, incrementing on hit or miss respectively;
  - counters reset to 0 with rst and wrap at 2**32-1 -> 0.
- Undefined: no counters and no extra ports. Functional behaviour is identical either way.

Test Plan:
- Reset, then load 0x0000_0040; memory returns 0xAAAA_0000 and 0xAAAA_0001 for the two words -> two read requests at 0x40 and 0x44, one response with rdata 0xAAAA_0000; a second load of 0x44 hits with rdata 0xAAAA_0001, 1 cycle after accept, no mem_req_valid.
- Conflict: load 0x0000_0040 then 0x0000_0080 (same index 0, different tag) -> both miss; a third load of 0x40 misses again and refetches.
- Store 0x0000_0044 = 0x1234_5678 after the line is filled -> one memory write at 0x44; a following load of 0x44 hits with 0x1234_5678.
- Store miss to 0x0000_0100 -> memory write only; a following load of 0x100 misses, proving no allocation.
- mem_req_ready held low for 5 cycles during REFILL -> mem_addr and mem_req_valid stable for all 5 cycles; cpu_req_ready stays 0.
- rst pulsed during RWAIT -> outputs return to reset values at once; the next load of the same address misses.
